// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// widths, FSM state and operation encodings, and the two's-complement magnitude helper.
package multdiv_unit_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ITER   = 32;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned DEST_W = 5;

    localparam logic [DEST_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    // Magnitude is one bit wider than the operand so that 0x80000000 maps to 2^31.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] ext;
        ext = {x[WIDTH-1], x};
        return x[WIDTH-1] ? -ext : ext;
    endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// Start request and writeback result bundle of the multiply/divide unit.
//   master: issues ctrl_MULT/ctrl_DIV with operands and destination, observes results.
//   slave : the unit; returns data_result/data_exception with a one-cycle
//           data_resultRDY pulse, the writeback strobe/address and ctrl_busy.
interface multdiv_unit_if;
    import multdiv_unit_pkg::*;

    logic                  ctrl_MULT;
    logic                  ctrl_DIV;
    logic [WIDTH-1:0]      data_operandA;
    logic [WIDTH-1:0]      data_operandB;
    logic [DEST_W-1:0]     ctrl_destReg;
    logic [WIDTH-1:0]      data_result;
    logic                  data_exception;
    logic                  data_resultRDY;
    logic                  ctrl_wbWriteEnable;
    logic [DEST_W-1:0]     ctrl_wbWriteReg;
    logic                  ctrl_busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_destReg,
        input  data_result, data_exception, data_resultRDY,
               ctrl_wbWriteEnable, ctrl_wbWriteReg, ctrl_busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_destReg,
        output data_result, data_exception, data_resultRDY,
               ctrl_wbWriteEnable, ctrl_wbWriteReg, ctrl_busy
    );

endinterface

// File: rtl/multdiv_datapath.sv
// Shift/add multiplier and restoring divider on operand magnitudes, with sign fix-up.
//   clk, rst_n        : clock, async active-low reset
//   load              : latch operands/op (start edge)
//   step              : one iteration (one bit per edge)
//   finish            : apply signs and register result/exception
//   op, opnd_a, opnd_b: operation and operands, sampled on load
//   result, exception : registered result, held until the next finish
module multdiv_datapath
    import multdiv_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  op_e              op,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic [WIDTH-1:0] opnd_b,
    output logic [WIDTH-1:0] result,
    output logic             exception
);

    op_e                op_q;
    logic               neg_q;
    logic               div0_q;
    // Multiply: mcand shifts left, mplier shifts right, acc holds the product.
    // Divide: mcand holds the divisor, mplier the dividend turning into the quotient,
    // acc the partial remainder.
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;

    logic [WIDTH:0]     mag_a;
    logic [WIDTH:0]     mag_b;
    logic [2*WIDTH-1:0] acc_add;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   rem_diff;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;

    // Iteration arithmetic and sign fix-up
    always_comb begin
        mag_a     = magnitude(opnd_a);
        mag_b     = magnitude(opnd_b);
        acc_add   = acc_q + (mplier_q[0] ? mcand_q : '0);
        rem_shift = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
        rem_diff  = {1'b0, rem_shift} - {1'b0, mcand_q[WIDTH:0]};
        prod_s    = neg_q ? -acc_q : acc_q;
        quot_s    = neg_q ? -mplier_q : mplier_q;
    end

    // Operand registers and iteration state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_MULT;
            neg_q     <= 1'b0;
            div0_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            result    <= '0;
            exception <= 1'b0;
        end else if (load) begin
            op_q     <= op;
            neg_q    <= opnd_a[WIDTH-1] ^ opnd_b[WIDTH-1];
            div0_q   <= (opnd_b == '0);
            mcand_q  <= (op == OP_MULT) ? (2*WIDTH)'(mag_a) : (2*WIDTH)'(mag_b);
            mplier_q <= (op == OP_MULT) ? mag_b[WIDTH-1:0] : mag_a[WIDTH-1:0];
            acc_q    <= '0;
        end else if (step) begin
            if (op_q == OP_MULT) begin
                acc_q    <= acc_add;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end else if (!rem_diff[WIDTH+1]) begin
                acc_q    <= (2*WIDTH)'(rem_diff[WIDTH:0]);
                mplier_q <= {mplier_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_q    <= (2*WIDTH)'(rem_shift);
                mplier_q <= {mplier_q[WIDTH-2:0], 1'b0};
            end
        end else if (finish) begin
            if (op_q == OP_MULT) begin
                result    <= prod_s[WIDTH-1:0];
                exception <= (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
            end else if (div0_q) begin
                result    <= '0;
                exception <= 1'b1;
            end else begin
                // A positive quotient of 2^31 only arises from 0x80000000 / -1.
                result    <= quot_s;
                exception <= ~neg_q & mplier_q[WIDTH-1];
            end
        end
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply/divide unit with register-file writeback.
//   clock, ctrl_reset_n : clock, async active-low reset
//   bus (slave)         : start pulses + operands + destination in;
//                         result, exception, resultRDY pulse, writeback strobe/address,
//                         busy stall out. Fixed latency: start at E0, result after E33.
module multdiv_unit
    import multdiv_unit_pkg::*;
(
    input  logic          clock,
    input  logic          ctrl_reset_n,
    multdiv_unit_if.slave bus
);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [DEST_W-1:0]  dest_q;
    logic               rdy_q;
    logic               we_q;
    logic [DEST_W-1:0]  wb_reg_q;
    logic               busy_q;

    logic               start_c;
    logic               load_c;
    logic               step_c;
    logic               finish_c;
    op_e                op_c;

    // Datapath controls decoded from the current state
    always_comb begin
        start_c  = bus.ctrl_MULT | bus.ctrl_DIV;
        op_c     = bus.ctrl_MULT ? OP_MULT : OP_DIV;
        load_c   = (state == ST_IDLE) & start_c;
        step_c   = (state == ST_RUN);
        finish_c = (state == ST_DONE);
    end

    // Sequencer, iteration counter and writeback outputs
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dest_q   <= '0;
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            wb_reg_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            we_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        state  <= ST_RUN;
                        cnt    <= '0;
                        dest_q <= bus.ctrl_destReg;
                        busy_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy_q   <= 1'b0;
                    rdy_q    <= 1'b1;
                    we_q     <= (dest_q != REG_ZERO);
                    wb_reg_q <= dest_q;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    multdiv_datapath u_datapath (
        .clk       (clock),
        .rst_n     (ctrl_reset_n),
        .load      (load_c),
        .step      (step_c),
        .finish    (finish_c),
        .op        (op_c),
        .opnd_a    (bus.data_operandA),
        .opnd_b    (bus.data_operandB),
        .result    (bus.data_result),
        .exception (bus.data_exception)
    );

    assign bus.data_resultRDY     = rdy_q;
    assign bus.ctrl_wbWriteEnable = we_q;
    assign bus.ctrl_wbWriteReg    = wb_reg_q;
    assign bus.ctrl_busy          = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed-vector bench for multdiv_unit with hand-computed expected results.
module tb_multdiv_unit;

    logic clock;
    logic ctrl_reset_n;
    int   total;
    int   bad;

    multdiv_unit_if bus ();

    multdiv_unit dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op at the next edge (E0) and check the full result timing through E34.
    // inj > 0 pulses ctrl_DIV with other operands before edge inj of the run.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst,
                          input logic [31:0] exp_r, input logic exp_x, input int inj);
        int stray;
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_destReg  = dst;
        @(posedge clock); #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        bus.ctrl_destReg  = 5'd31;
        chk({tag, "_busy_start"}, 32'(bus.ctrl_busy), 32'd1);
        stray = 0;
        for (int i = 1; i <= 33; i++) begin
            if (i == inj) begin
                bus.ctrl_DIV      = 1'b1;
                bus.data_operandA = 32'd999;
                bus.data_operandB = 32'd1;
                bus.ctrl_destReg  = 5'd7;
            end else begin
                bus.ctrl_DIV = 1'b0;
            end
            @(posedge clock); #1;
            if (i < 33 && (bus.data_resultRDY || !bus.ctrl_busy)) stray++;
        end
        chk({tag, "_stray"},  32'(stray), 32'd0);
        chk({tag, "_result"}, bus.data_result, exp_r);
        chk({tag, "_exc"},    32'(bus.data_exception), 32'(exp_x));
        chk({tag, "_rdy"},    32'(bus.data_resultRDY), 32'd1);
        chk({tag, "_we"},     32'(bus.ctrl_wbWriteEnable), 32'(dst != 5'd0));
        chk({tag, "_wbreg"},  32'(bus.ctrl_wbWriteReg), 32'(dst));
        chk({tag, "_busy"},   32'(bus.ctrl_busy), 32'd0);
        @(posedge clock); #1;
        chk({tag, "_rdy_off"}, 32'(bus.data_resultRDY), 32'd0);
        chk({tag, "_we_off"},  32'(bus.ctrl_wbWriteEnable), 32'd0);
        chk({tag, "_hold"},    bus.data_result, exp_r);
        chk({tag, "_wbhold"},  32'(bus.ctrl_wbWriteReg), 32'(dst));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"}, bus.data_result, 32'd0);
        chk({tag, "_exc"},    32'(bus.data_exception), 32'd0);
        chk({tag, "_rdy"},    32'(bus.data_resultRDY), 32'd0);
        chk({tag, "_we"},     32'(bus.ctrl_wbWriteEnable), 32'd0);
        chk({tag, "_wbreg"},  32'(bus.ctrl_wbWriteReg), 32'd0);
        chk({tag, "_busy"},   32'(bus.ctrl_busy), 32'd0);
    endtask

    initial begin
        int pulses;
        total = 0;
        bad   = 0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_destReg  = '0;
        ctrl_reset_n      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(posedge clock); #1;

        run_op("mul_7x-6",   1'b1, 1'b0, 32'd7,        32'hFFFF_FFFA, 5'd5, 32'hFFFF_FFD6, 1'b0, 0);
        run_op("mul_ovf",    1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd3, 32'h0000_0000, 1'b1, 0);
        run_op("mul_min_x1", 1'b1, 1'b0, 32'h8000_0000, 32'd1,         5'd4, 32'h8000_0000, 1'b0, 0);
        run_op("mul_m1xm1",  1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'd1,         1'b0, 0);
        run_op("div_-7/2",   1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         5'd9, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("div_-100/-7",1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd8, 32'd14,        1'b0, 0);
        run_op("div_by0",    1'b0, 1'b1, 32'd100,       32'd0,         5'd10, 32'd0,        1'b1, 0);
        run_op("div_ovf",    1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1, 0);
        run_op("mul_dest0",  1'b1, 1'b0, 32'd5,         32'd5,         5'd0, 32'd25,        1'b0, 0);
        run_op("mul_ign_div",1'b1, 1'b0, 32'd1234,      32'hFFFF_FFFD, 5'd12, 32'hFFFF_F18A, 1'b0, 10);
        run_op("both_start", 1'b1, 1'b1, 32'd20,        32'd4,         5'd13, 32'd80,       1'b0, 0);
        run_op("div_pre_rst",1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         5'd9, 32'hFFFF_FFFD, 1'b0, 0);

        // Abort a divide at cycle 15 with an asynchronous reset.
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = 32'd1000;
        bus.data_operandB = 32'd7;
        bus.ctrl_destReg  = 5'd14;
        @(posedge clock); #1;
        bus.ctrl_DIV = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        chk("mid_busy", 32'(bus.ctrl_busy), 32'd1);
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clock);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus.data_resultRDY || bus.ctrl_busy) pulses++;
        end
        chk("post_rst_quiet", 32'(pulses), 32'd0);

        run_op("mul_3x4",    1'b1, 1'b0, 32'd3,         32'd4,         5'd2, 32'd12,        1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative 32-bit signed multiply/divide unit in the execute stage, directly upstream of the register file.
- Accepts a one-cycle start pulse with operands and a destination register.
- After a fixed multi-cycle latency, presents the result with a one-cycle write strobe and write address that drive the register file write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg).
- Stalls the pipeline via a busy output.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- ITER, 32, iteration count (equals WIDTH).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- ctrl_reset_n  input  1  asynchronous, active-low reset.
- ctrl_MULT  input  1  start-multiply pulse, sampled at the rising edge.
- ctrl_DIV  input  1  start-divide pulse, sampled at the rising edge.
- data_operandA  input  32  multiplicand / dividend (two's complement).
- data_operandB  input  32  multiplier / divisor (two's complement).
- ctrl_destReg  input  5  destination register captured at start.
- data_result  output  32  product low word or quotient.
- data_exception  output  1  overflow or divide-by-zero flag, valid with data_resultRDY.
- data_resultRDY  output  1  one-cycle result-valid pulse.
- ctrl_wbWriteEnable  output  1  data_resultRDY AND (wbWriteReg != 0).
- ctrl_wbWriteReg  output  5  captured destination register.
- ctrl_busy  output  1  high from the start edge until the result edge; used as a pipeline stall.

Behaviour:
- Reset: asynchronous and active-low, as already decided.
  - Asserting ctrl_reset_n low forces state IDLE, counter 0, and all outputs 0: data_result, data_exception, data_resultRDY, ctrl_wbWriteEnable, ctrl_wbWriteReg, ctrl_busy.
- FSM states:
  - IDLE -> RUN on a start edge.
  - RUN -> DONE when the counter reaches ITER-1 at an edge.
  - DONE -> IDLE unconditionally.
- Start (edge E0, IDLE only):
  - If ctrl_MULT=1, start a multiply. MULT has priority when both ctrl_MULT and ctrl_DIV are 1.
  - Else if ctrl_DIV=1, start a divide.
  - Latch operands, ctrl_destReg and the op type; clear the counter; ctrl_busy=1.
- Start pulses while in RUN or DONE are ignored: no queueing, latched operands unchanged.
- Multiply:
  - Radix-2 shift-add over the sign-corrected magnitudes, one bit per edge, edges E1..E32.
  - Signs applied at the final step.
  - Full 64-bit product kept internally; data_result = low 32 bits.
  - data_exception=1 iff the 64-bit product is not the sign-extension of bit 31.
- Divide:
  - Restoring division on magnitudes, one quotient bit per edge, E1..E32.
  - Quotient truncates toward zero; remainder is discarded.
  - Quotient is negated when the operand signs differ.
  - Divisor 0: result 0x00000000, exception 1. Detected at E0; the iterations still run so latency stays fixed.
  - 0x80000000 / 0xFFFFFFFF: result 0x80000000, exception 1.
- Result timing:
  - The result is registered at E33 (DONE).
  - data_resultRDY=1 and ctrl_wbWriteEnable as defined above for exactly the cycle following E33.
  - ctrl_busy falls at E33.
  - Fixed latency: start sampled at E0, result visible after E33.
- Output hold:
  - data_result, data_exception and ctrl_wbWriteReg hold their values after the pulse until the next result.
  - data_resultRDY and ctrl_wbWriteEnable return to 0 at E34.
- Back-to-back: a new start is accepted at E34 (IDLE); the earliest throughput is one op per 34 cycles.
- Reset mid-operation: the operation is aborted, no data_resultRDY is produced, and the unit is idle after reset is released.
- Destination register 0: the result is still computed and data_resultRDY still pulses, but ctrl_wbWriteEnable stays 0.
- Width rules:
  - All arithmetic in two's complement.
  - Magnitude of 0x80000000 is 2^31, held in a 33-bit internal value.
  - Counter is 6 bits.

Decomposition:
- Shared package holds:
  - state encodings: ST_IDLE, ST_RUN, ST_DONE;
  - op encodings: OP_MULT, OP_DIV;
  - constants: WIDTH=32, ITER=32, REG_ZERO=5'd0.
- One natural sub-module: multdiv_datapath.
  - Contains the shift registers, the add/subtract step, and the sign fix-up.
  - Takes op, step and load controls from the FSM in multdiv_unit.
  - The top level keeps the FSM, the counter, the destination latch and the writeback outputs.

Test Plan:
- Multiply 7 x -6, dest 5 -> after 33 edges data_result=0xFFFFFFD6 (-42), exception 0, resultRDY and wbWriteEnable high 1 cycle, wbWriteReg=5.
- Multiply 0x00010000 x 0x00010000, dest 3 -> data_result=0x00000000, exception 1; also 0x80000000 x 1 -> 0x80000000, exception 0.
- Divide -7 / 2, dest 9 -> data_result=0xFFFFFFFD (-3), exception 0; divide 100 / 0 -> result 0, exception 1, still 33-edge latency.
- Divide 0x80000000 / -1 -> result 0x80000000, exception 1; multiply 5 x 5 dest 0 -> data_result=25, resultRDY=1, wbWriteEnable=0.
- Pulse ctrl_DIV with new operands at cycle 10 of a running multiply -> ignored: the multiply result is correct and only one resultRDY pulse occurs; ctrl_MULT and ctrl_DIV together -> multiply performed.
- Assert ctrl_reset_n=0 at cycle 15 of a divide -> all outputs 0 immediately (asynchronous); after release no resultRDY appears; a new multiply 3 x 4 yields 12 at the expected latency.
